// File: rtl/line_draw_sched.sv
// Round-robin scheduler sharing one Bresenham rasterizer between NUM_REQ requesters,
// plus the engine buffer-clear sequence. Define LINE_DRAW_SCHED_PERF_EN to add lines_drawn.
module line_draw_sched #(
  parameter int unsigned NUM_REQ = 2
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [32*NUM_REQ-1:0] req_coord,
  output logic [NUM_REQ-1:0]    ack,
  output logic [NUM_REQ-1:0]    fin,
  input  logic                  clr_req,
  output logic                  clr_ack,
  output logic                  busy,
  output logic [1:0]            grant_id,
  output logic [7:0]            eng_x0,
  output logic [7:0]            eng_y0,
  output logic [7:0]            eng_x1,
  output logic [7:0]            eng_y1,
  output logic                  eng_start,
  output logic                  eng_reset_buff,
`ifdef LINE_DRAW_SCHED_PERF_EN
  input  logic                  eng_done,
  output logic [15:0]           lines_drawn
`else
  input  logic                  eng_done
`endif
);

  localparam int unsigned GW    = 2;
  localparam int unsigned CW    = 32;
  localparam int unsigned MAXR  = 4;
  localparam int unsigned PADW  = MAXR * CW;

  typedef struct packed {
    logic [7:0] x0;
    logic [7:0] y0;
    logic [7:0] x1;
    logic [7:0] y1;
  } coord_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ISSUE,
    ST_WAIT_DONE,
    ST_CLR_SET,
    ST_CLR_WAIT,
    ST_CLR_EXIT
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                w_grant_en;
  logic                w_fin_en;
  logic                w_busy_nxt;
  logic                w_start_nxt;
  logic                w_rbuf_nxt;
  logic                w_clr_ack_nxt;

  logic [GW-1:0]       r_last_grant;
  logic [GW-1:0]       r_grant_id;
  coord_t              r_coord;
  logic [NUM_REQ-1:0]  r_ack;
  logic [NUM_REQ-1:0]  r_fin;
  logic                r_busy;
  logic                r_eng_start;
  logic                r_eng_reset_buff;
  logic                r_clr_ack;

  logic [MAXR-1:0]     w_req_pad;
  logic                w_any_req;
  logic [GW-1:0]       w_pick;
  logic [MAXR-1:0]     w_oh_pick;
  logic [MAXR-1:0]     w_oh_last;
  logic [PADW-1:0]     w_coord_pad;
  coord_t              w_coord_arr [MAXR];

  // Unused requester slots are zero-padded so every lookup is a full 4-entry table.
  assign w_coord_pad = PADW'(req_coord);
  for (genvar g = 0; g < MAXR; g++) begin : g_coord
    assign w_coord_arr[g] = w_coord_pad[CW*g +: CW];
  end

  // Round-robin pick: scan downward so the nearest requester after last_grant wins.
  always_comb begin
    w_req_pad = MAXR'(req);
    w_any_req = 1'b0;
    w_pick    = r_last_grant;
    for (int unsigned k = NUM_REQ; k > 0; k--) begin
      if (w_req_pad[GW'((32'(r_last_grant) + k) % NUM_REQ)]) begin
        w_any_req = 1'b1;
        w_pick    = GW'((32'(r_last_grant) + k) % NUM_REQ);
      end
    end
  end

  assign w_oh_pick = MAXR'(1) << w_pick;
  assign w_oh_last = MAXR'(1) << r_last_grant;

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grant_en  = 1'b0;
    w_fin_en    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (clr_req) begin
          w_state_nxt = ST_CLR_SET;
        end else if (w_any_req) begin
          w_state_nxt = ST_SETUP;
          w_grant_en  = 1'b1;
        end
      end
      ST_SETUP:     w_state_nxt = ST_ISSUE;
      ST_ISSUE:     w_state_nxt = ST_WAIT_DONE;
      ST_WAIT_DONE: begin
        if (eng_done) begin
          w_state_nxt = ST_IDLE;
          w_fin_en    = 1'b1;
        end
      end
      ST_CLR_SET:   w_state_nxt = ST_CLR_WAIT;
      ST_CLR_WAIT:  w_state_nxt = ST_CLR_EXIT;
      ST_CLR_EXIT:  w_state_nxt = ST_IDLE;
      default:      w_state_nxt = ST_IDLE;
    endcase
    // The clear-exit start pulse releases the engine from its clear state.
    w_busy_nxt    = (w_state_nxt != ST_IDLE);
    w_start_nxt   = (w_state_nxt == ST_ISSUE) || (w_state_nxt == ST_CLR_EXIT);
    w_rbuf_nxt    = (w_state_nxt == ST_CLR_SET);
    w_clr_ack_nxt = (w_state_nxt == ST_CLR_EXIT);
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      r_last_grant     <= GW'(NUM_REQ - 1);
      r_grant_id       <= '0;
      r_coord          <= '0;
      r_ack            <= '0;
      r_fin            <= '0;
      r_busy           <= 1'b0;
      r_eng_start      <= 1'b0;
      r_eng_reset_buff <= 1'b0;
      r_clr_ack        <= 1'b0;
    end else begin
      r_ack            <= w_grant_en ? w_oh_pick[NUM_REQ-1:0] : '0;
      r_fin            <= w_fin_en ? w_oh_last[NUM_REQ-1:0] : '0;
      r_busy           <= w_busy_nxt;
      r_eng_start      <= w_start_nxt;
      r_eng_reset_buff <= w_rbuf_nxt;
      r_clr_ack        <= w_clr_ack_nxt;
      // Coordinates only move at grant, so they stay frozen until eng_done.
      if (w_grant_en) begin
        r_last_grant <= w_pick;
        r_grant_id   <= w_pick;
        r_coord      <= w_coord_arr[w_pick];
      end
    end
  end

  assign ack            = r_ack;
  assign fin            = r_fin;
  assign busy           = r_busy;
  assign clr_ack        = r_clr_ack;
  assign grant_id       = r_grant_id;
  assign eng_x0         = r_coord.x0;
  assign eng_y0         = r_coord.y0;
  assign eng_x1         = r_coord.x1;
  assign eng_y1         = r_coord.y1;
  assign eng_start      = r_eng_start;
  assign eng_reset_buff = r_eng_reset_buff;

`ifdef LINE_DRAW_SCHED_PERF_EN
  logic [15:0] r_lines;

  // Completed-line counter; wraps naturally and is zeroed by a buffer clear.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      r_lines <= '0;
    end else if (r_clr_ack) begin
      r_lines <= '0;
    end else if (|r_fin) begin
      r_lines <= r_lines + 16'd1;
    end
  end

  assign lines_drawn = r_lines;
`endif

endmodule

// File: tb/tb_line_draw_sched.sv
// Directed bench for line_draw_sched: grant/issue/complete timing, round-robin,
// clear priority, clear while busy, mid-operation reset and spurious done.
module tb_line_draw_sched;

  localparam int unsigned NR = 2;

  logic            clk = 1'b0;
  logic            n_rst;
  logic [NR-1:0]   req;
  logic [32*NR-1:0] req_coord;
  logic [NR-1:0]   ack;
  logic [NR-1:0]   fin;
  logic            clr_req;
  logic            clr_ack;
  logic            busy;
  logic [1:0]      grant_id;
  logic [7:0]      eng_x0, eng_y0, eng_x1, eng_y1;
  logic            eng_start;
  logic            eng_reset_buff;
  logic            eng_done;
`ifdef LINE_DRAW_SCHED_PERF_EN
  logic [15:0]     lines_drawn;
`endif

  logic [7:0]      obs;
  logic [31:0]     crd;
  int              n_cmp = 0;
  int              n_err = 0;
  logic [1:0]      g;
  logic [1:0]      oh;

  line_draw_sched #(.NUM_REQ(NR)) dut (
    .clk            (clk),
    .n_rst          (n_rst),
    .req            (req),
    .req_coord      (req_coord),
    .ack            (ack),
    .fin            (fin),
    .clr_req        (clr_req),
    .clr_ack        (clr_ack),
    .busy           (busy),
    .grant_id       (grant_id),
    .eng_x0         (eng_x0),
    .eng_y0         (eng_y0),
    .eng_x1         (eng_x1),
    .eng_y1         (eng_y1),
    .eng_start      (eng_start),
    .eng_reset_buff (eng_reset_buff),
`ifdef LINE_DRAW_SCHED_PERF_EN
    .eng_done       (eng_done),
    .lines_drawn    (lines_drawn)
`else
    .eng_done       (eng_done)
`endif
  );

  always #5 clk = ~clk;

  // Bit layout: {ack[1:0], fin[1:0], clr_ack, busy, eng_start, eng_reset_buff}
  assign obs = {ack, fin, clr_ack, busy, eng_start, eng_reset_buff};
  assign crd = {eng_x0, eng_y0, eng_x1, eng_y1};

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    n_cmp++;
    assert (o === e) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, o, e);
    end
  endtask

  task automatic chk_sig(input string tag, input logic [7:0] e);
    chk(tag, 32'(obs), 32'(e));
  endtask

  task automatic chk_lines(input string tag, input logic [15:0] e);
`ifdef LINE_DRAW_SCHED_PERF_EN
    chk(tag, 32'(lines_drawn), 32'(e));
`else
    if (e === 16'hxxxx) $display("%s", tag);
`endif
  endtask

  initial begin
    n_rst = 1'b0; req = '0; req_coord = '0; clr_req = 1'b0; eng_done = 1'b0;
    repeat (3) step();
    chk_sig("rst_sig", 8'b00000000);
    chk("rst_gid", 32'(grant_id), 32'd0);
    chk("rst_crd", crd, 32'h0);
    chk_lines("rst_lines", 16'd0);
    n_rst = 1'b1;

    // Round-robin with both requesters held high
    step(); chk_sig("rr_idle", 8'b00000000);
    req = 2'b11; req_coord = {32'h0A0B0C0D, 32'h01020304};
    for (int k = 0; k < 4; k++) begin
      g  = 2'(k % 2);
      oh = 2'b01 << g;
      step(); chk_sig("rr_ack", {oh, 2'b00, 4'b0100});
      chk("rr_gid", 32'(grant_id), 32'(g));
      chk("rr_crd", crd, (g == 2'd1) ? 32'h0A0B0C0D : 32'h01020304);
      step(); chk_sig("rr_start", 8'b00000110);
      step(); chk_sig("rr_wait", 8'b00000100); eng_done = 1'b1;
      step(); chk_sig("rr_fin", {2'b00, oh, 4'b0000}); eng_done = 1'b0;
      if (k == 3) req = '0;
    end

    // Single draw from requester 0 with {2,3,10,7}
    step(); chk_sig("sd_idle", 8'b00000000); chk_lines("rr_lines", 16'd4);
    req = 2'b01; req_coord = {32'hFFFFFFFF, 32'h02030A07};
    step(); chk_sig("sd_ack", 8'b01000100);
    chk("sd_crd", crd, 32'h02030A07);
    chk("sd_gid", 32'(grant_id), 32'd0);
    req = '0;
    step(); chk_sig("sd_start", 8'b00000110);
    req_coord = {32'hFFFFFFFF, 32'h55555555};
    for (int i = 3; i <= 20; i++) begin
      step(); chk_sig("sd_wait", 8'b00000100);
    end
    chk("sd_crd_hold", crd, 32'h02030A07);
    eng_done = 1'b1;
    step(); chk_sig("sd_fin", 8'b00010000); eng_done = 1'b0;

    // Clear request wins over a pending draw
    step(); chk_sig("cp_idle", 8'b00000000); chk_lines("sd_lines", 16'd5);
    clr_req = 1'b1; req = 2'b10; req_coord = {32'h11223344, 32'h00000000};
    step(); chk_sig("cp_rbuf", 8'b00000101);
    step(); chk_sig("cp_cwait", 8'b00000100);
    step(); chk_sig("cp_exit", 8'b00001110); clr_req = 1'b0;
    step(); chk_sig("cp_idle4", 8'b00000000); chk_lines("cp_lines_clr", 16'd0);
    step(); chk_sig("cp_ack1", 8'b10000100);
    chk("cp_gid", 32'(grant_id), 32'd1);
    chk("cp_crd", crd, 32'h11223344);
    req = '0;
    step(); chk_sig("cp_start", 8'b00000110);
    step(); chk_sig("cp_wait", 8'b00000100); eng_done = 1'b1;
    step(); chk_sig("cp_fin", 8'b00100000); eng_done = 1'b0;

    // Clear raised while a line is in flight
    step(); chk_sig("cb_idle", 8'b00000000); chk_lines("cp_lines", 16'd1);
    req = 2'b01; req_coord = {32'h00000000, 32'h05060708};
    step(); chk_sig("cb_ack", 8'b01000100); req = '0;
    step(); chk_sig("cb_start", 8'b00000110);
    step(); chk_sig("cb_wait0", 8'b00000100); clr_req = 1'b1;
    step(); chk_sig("cb_wait1", 8'b00000100);
    step(); chk_sig("cb_wait2", 8'b00000100); eng_done = 1'b1;
    step(); chk_sig("cb_fin", 8'b00010000); eng_done = 1'b0;
    step(); chk_sig("cb_rbuf", 8'b00000101); chk_lines("cb_lines", 16'd2);
    step(); chk_sig("cb_cwait", 8'b00000100);
    step(); chk_sig("cb_exit", 8'b00001110); clr_req = 1'b0;
    step(); chk_sig("cb_idle2", 8'b00000000); chk_lines("cb_lines_clr", 16'd0);

    // Reset in WAIT_DONE aborts without fin
    req = 2'b01; req_coord = {32'h00000000, 32'h09080706};
    step(); chk_sig("mr_ack", 8'b01000100); req = '0;
    step(); chk_sig("mr_start", 8'b00000110);
    step(); chk_sig("mr_wait", 8'b00000100); n_rst = 1'b0;
    step(); chk_sig("mr_zero", 8'b00000000);
    chk("mr_gid", 32'(grant_id), 32'd0);
    chk("mr_crd", crd, 32'h0);
    chk_lines("mr_lines", 16'd0);
    n_rst = 1'b1; req = 2'b10; req_coord = {32'h0C0D0E0F, 32'h00000000};
    step(); chk_sig("mr_ack1", 8'b10000100);
    chk("mr_gid1", 32'(grant_id), 32'd1);
    chk("mr_crd1", crd, 32'h0C0D0E0F);
    req = '0;
    step(); chk_sig("mr_start1", 8'b00000110);
    step(); chk_sig("mr_wait1", 8'b00000100); eng_done = 1'b1;
    step(); chk_sig("mr_fin1", 8'b00100000); eng_done = 1'b0;

    // Spurious done in IDLE and SETUP is ignored
    step(); chk_sig("sp_idle", 8'b00000000); chk_lines("mr_lines1", 16'd1);
    eng_done = 1'b1;
    step(); chk_sig("sp_idle_done", 8'b00000000); chk_lines("sp_lines_idle", 16'd1);
    req = 2'b01; req_coord = {32'h00000000, 32'h01010202};
    step(); chk_sig("sp_ack", 8'b01000100); req = '0;
    step(); chk_sig("sp_start", 8'b00000110); eng_done = 1'b0;
    chk_lines("sp_lines_setup", 16'd1);
    step(); chk_sig("sp_wait0", 8'b00000100);
    step(); chk_sig("sp_wait1", 8'b00000100); eng_done = 1'b1;
    step(); chk_sig("sp_fin", 8'b00010000); eng_done = 1'b0;
    step(); chk_sig("sp_idle_end", 8'b00000000); chk_lines("sp_lines_end", 16'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
